// File: rtl/jtag_frame_loader_if.sv
// Host-side chunk handshake between the JTAG mailbox and jtag_frame_loader.
// Level handshake: the master holds iNEXT until it sees oACK.
interface jtag_frame_loader_if #(
    parameter int WORD_W      = 32,
    parameter int CHUNK_WORDS = 14
);
    logic [WORD_W*CHUNK_WORDS-1:0] iCHUNK_DATA;
    logic                          iNEXT;
    logic                          iFINISH;
    logic                          oACK;

    modport master (output iCHUNK_DATA, output iNEXT, output iFINISH, input oACK);
    modport slave  (input iCHUNK_DATA, input iNEXT, input iFINISH, output oACK);
endinterface

// File: rtl/jtag_frame_loader.sv
// Assembles host chunks into a frame, then gates the network clock and fires a start pulse.
// Optional macro FRAME_CLEAR_EN: the first chunk of a frame zeroes every other frame bit.
//
// state | meaning
// IDLE  | no partial frame held
// LOAD  | partial frame held, waiting for more chunks
// ARM   | last chunk captured, counting down the start delay
// FIRE  | start pulse asserted for one cycle
module jtag_frame_loader #(
    parameter  int WORD_W      = 32,
    parameter  int CHUNK_WORDS = 14,
    parameter  int FRAME_BITS  = 800,
    parameter  int START_DELAY = 2,
    localparam int CHUNK_BITS  = WORD_W * CHUNK_WORDS,
    localparam int MAX_CHUNKS  = (FRAME_BITS + CHUNK_BITS - 1) / CHUNK_BITS,
    localparam int CNT_W       = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    jtag_frame_loader_if.slave    host,
    output logic [FRAME_BITS-1:0] oFRAME,
    output logic                  oFRAME_VALID,
    output logic                  oSTART,
    output logic                  oCLK_EN,
    output logic [CNT_W-1:0]      oCHUNK_CNT,
    output logic                  oOVERFLOW
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_FIRE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            dly_q, dly_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;

    logic                  capture;
    logic [CNT_W-1:0]      idx;

    // The chunk index restarts at 0 whenever a frame ends, while cnt_q keeps the final count.
    assign idx     = (state_q == S_IDLE) ? '0 : cnt_q;
    assign capture = ((state_q == S_IDLE) || (state_q == S_LOAD)) && host.iNEXT && !ack_q;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        frame_d = frame_q;
        // Ack stays up while the host holds iNEXT, so each assertion captures once.
        ack_d   = ack_q ? host.iNEXT : capture;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (capture) begin
                    if (host.iFINISH) begin
                        state_d = S_ARM;
                        dly_d   = 8'(START_DELAY - 1);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_ARM: begin
                if (dly_q == '0) state_d = S_FIRE;
                else             dly_d   = dly_q - 8'd1;
            end
            S_FIRE: begin
                state_d = S_IDLE;
                valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            valid_d = 1'b0;
            if (state_q == S_IDLE)                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt_q != {CNT_W{1'b1}})      cnt_d = cnt_q + 1'b1;
            if (int'(idx) >= MAX_CHUNKS)          ovf_d = 1'b1;
`ifdef FRAME_CLEAR_EN
            if (idx == '0) frame_d = '0;
`else
`endif
            // Slots past the frame end simply never match, so overflow chunks write nothing.
            for (int b = 0; b < FRAME_BITS; b++) begin
                if (b / CHUNK_BITS == int'(idx)) frame_d[b] = host.iCHUNK_DATA[b % CHUNK_BITS];
            end
        end
    end

    assign host.oACK    = ack_q;
    assign oFRAME       = frame_q;
    assign oFRAME_VALID = valid_q;
    assign oSTART       = (state_q == S_FIRE);
    assign oCLK_EN      = (state_q == S_IDLE) || (state_q == S_FIRE);
    assign oCHUNK_CNT   = cnt_q;
    assign oOVERFLOW    = ovf_q;

endmodule
